// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and 7-segment constants for the product display path
//
// Purpose: state encoding for the BCD conversion FSM and active-low 7-segment
//          patterns, bit order {g,f,e,d,c,b,a} (segment lit when its bit is 0).
package mult_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD digit to active-low 7-segment decoder
//
// Purpose: map one BCD digit to its display pattern; codes 10-15 go blank.
// Ports:
//   digit  in   4  BCD digit
//   seg    out  7  active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg
  import mult_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) begin
      seg = SEG_LUT[digit];
    end
  end

endmodule

// File: rtl/mult_result_bcd.sv
// rtl/mult_result_bcd.sv - multiplier product capture, double-dabble BCD conversion, 7-seg drive
//
// Purpose: accept a binary product, convert it to BCD over IN_W shift cycles and
//          register the BCD value and 7-segment patterns when conversion completes.
//          Requires 10**DIGITS > 2**IN_W.
// Optional feature: OVF_DISPLAY_EN - when defined, a product captured with overflow=1
//          shows dashes on every digit (bcd still carries the converted value).
// Ports:
//   clk        in   1         system clock, rising edge
//   rst        in   1         asynchronous active-low reset
//   in_valid   in   1         product available on result/overflow
//   in_ready   out  1         converter idle, can accept a product
//   result     in   IN_W      binary product
//   overflow   in   1         multiplier overflow flag, sampled with result
//   bcd        out  4*DIGITS  packed BCD, digit 0 = units in [3:0]
//   seg        out  7*DIGITS  active-low segments per digit, digit 0 in [6:0]
//   out_valid  out  1         one-cycle pulse when bcd/seg update
module mult_result_bcd
  import mult_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       result,
  input  logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  out_valid
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_t             state;
  logic [IN_W-1:0]    shreg;
  logic [IN_W-1:0]    sh_next;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scr_next;
  logic [CNT_W-1:0]   cnt;
  logic [7*DIGITS-1:0] seg_next;
  logic [7*DIGITS-1:0] seg_final;

  assign in_ready = (state == IDLE);

  // Add-3 is applied per digit with no carry between digits; a digit >=5 becomes
  // >=8 so the following shift carries correctly into the next decimal digit.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  assign scr_next = {adj[BCD_W-2:0], shreg[IN_W-1]};
  assign sh_next  = {shreg[IN_W-2:0], 1'b0};

  // Decode the value the final shift produces so seg is registered together with bcd.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_to_seg u_dec (
      .digit (scr_next[4*g +: 4]),
      .seg   (seg_next[7*g +: 7])
    );
  end

`ifdef OVF_DISPLAY_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ovf_q <= overflow;
    end
  end

  assign seg_final = ovf_q ? {DIGITS{SEG_DASH}} : seg_next;
`else
  logic unused_overflow;

  assign unused_overflow = overflow;
  assign seg_final       = seg_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      scratch   <= '0;
      cnt       <= '0;
      bcd       <= '0;
      seg       <= '1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg   <= result;
            scratch <= '0;
            cnt     <= CNT_W'(IN_W);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scr_next;
          shreg   <= sh_next;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bcd       <= scr_next;
            seg       <= seg_final;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
